// File: rtl/mic_ulaw_packer.sv
// Captures microphone PCM samples, mu-law encodes them and packs four bytes per 32-bit word.
// Optional build macro MIC_SILENCE_PRELOAD_EN presents one silence word (0xFFFFFFFF) on entering ACTIVE.
module mic_ulaw_packer #(
  parameter int START_DELAY = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        record_start,
  input  logic        record_stop,
  input  logic        sample_avail,
  input  logic [15:0] sample_data,
  output logic [31:0] mic_data,
  output logic        mic_data_valid,
  input  logic        mic_data_retrieved,
  output logic [1:0]  mic_debug
);

  localparam int CW = (START_DELAY < 1) ? 1 : $clog2(START_DELAY + 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    ACTIVE
  } state_t;

  state_t          state;
  logic [CW-1:0]   delay_cnt;
  logic            word_filled;
  logic [1:0]      slot;
  logic            pending;
  logic [15:0]     holding;

  logic            avail_q1;
  logic            avail_q2;
  logic            avail_q3;
  logic            sample_event;
  logic            write_en;

  logic [12:0]     enc_s;
  logic [13:0]     enc_x;
  logic            enc_sign;
  logic [14:0]     enc_mag;
  logic [12:0]     enc_m;
  logic [12:0]     enc_b;
  logic [2:0]      enc_exp;
  logic [3:0]      enc_mant;
  logic [7:0]      enc_byte;

  // sample_avail is asynchronous: two flops for metastability, a third to find the rising edge.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail_q1 <= 1'b0;
      avail_q2 <= 1'b0;
      avail_q3 <= 1'b0;
    end else begin
      avail_q1 <= sample_avail;
      avail_q2 <= avail_q1;
      avail_q3 <= avail_q2;
    end
  end

  assign sample_event = avail_q2 & ~avail_q3;

  // NOTE: the holding register is a plain data register, so it is reset like any other flop
  // (it is not a memory array); this keeps the encoder input defined out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holding <= '0;
    end else if (sample_event) begin
      holding <= sample_data;
    end
  end

  // Mu-law encoder on the 13-bit sample taken from holding[15:3].
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    enc_s    = holding[15:3];
    enc_x    = {enc_s, 1'b0};
    enc_sign = enc_x[13];
    // 15-bit magnitude so that -8192 does not overflow before clipping.
    enc_mag  = enc_sign ? (15'd0 - {1'b1, enc_x}) : {1'b0, enc_x};
    enc_m    = (enc_mag > 15'd8158) ? 13'd8158 : enc_mag[12:0];
    enc_b    = enc_m + 13'd33;
    enc_exp  = '0;
    for (int i = 5; i < 13; i++) begin
      if (enc_b[i]) enc_exp = 3'(i - 5);
    end
    enc_mant = enc_b[({1'b0, enc_exp} + 4'd1) +: 4];
    enc_byte = ~{enc_sign, enc_exp, enc_mant};
  end

  logic unused_bits;
  assign unused_bits = ^{holding[2:0], enc_b[0]};

  assign write_en = (state == ACTIVE) && !word_filled && pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      delay_cnt   <= '0;
      word_filled <= 1'b0;
      slot        <= 2'd0;
      pending     <= 1'b0;
      mic_data    <= '0;
    end else begin
      // A fresh capture keeps pending set even when the old value is written this cycle.
      if (sample_event) begin
        pending <= 1'b1;
      end else if (write_en) begin
        pending <= 1'b0;
      end

      if (record_stop) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (record_start) begin
              state       <= DELAY;
              delay_cnt   <= '0;
              word_filled <= 1'b0;
              slot        <= 2'd0;
              pending     <= 1'b0;
            end
          end

          DELAY: begin
            if (delay_cnt == CW'(START_DELAY)) begin
              state   <= ACTIVE;
              // Anything captured before recording began is stale.
              pending <= 1'b0;
`ifdef MIC_SILENCE_PRELOAD_EN
              mic_data    <= '1;
              word_filled <= 1'b1;
              slot        <= 2'd0;
`endif
            end else begin
              delay_cnt <= delay_cnt + 1'b1;
            end
          end

          ACTIVE: begin
            if (record_start) begin
              state       <= DELAY;
              delay_cnt   <= '0;
              word_filled <= 1'b0;
              slot        <= 2'd0;
              pending     <= 1'b0;
            end else begin
              if (write_en) begin
                case (slot)
                  2'd0:    mic_data[31:24] <= enc_byte;
                  2'd1:    mic_data[23:16] <= enc_byte;
                  2'd2:    mic_data[15:8]  <= enc_byte;
                  default: mic_data[7:0]   <= enc_byte;
                endcase
                slot <= slot + 2'd1;
                if (slot == 2'd3) word_filled <= 1'b1;
              end
              if (mic_data_retrieved && word_filled) begin
                word_filled <= 1'b0;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mic_data_valid = (state == ACTIVE) && word_filled;
  assign mic_debug      = {mic_data_valid, state == ACTIVE};

endmodule

// File: tb/tb_mic_ulaw_packer.sv
// Self-checking bench for mic_ulaw_packer: scoreboard of expected mu-law bytes, one task per scenario.
// Honours MIC_SILENCE_PRELOAD_EN when defined for the build.
module tb_mic_ulaw_packer;

  localparam int START_DELAY = 10;

  logic        clk;
  logic        rst_n;
  logic        record_start;
  logic        record_stop;
  logic        sample_avail;
  logic [15:0] sample_data;
  logic [31:0] mic_data;
  logic        mic_data_valid;
  logic        mic_data_retrieved;
  logic [1:0]  mic_debug;

  int tests_run;
  int tests_failed;
  logic [7:0] exp_q[$];

  mic_ulaw_packer #(.START_DELAY(START_DELAY)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .record_start       (record_start),
    .record_stop        (record_stop),
    .sample_avail       (sample_avail),
    .sample_data        (sample_data),
    .mic_data           (mic_data),
    .mic_data_valid     (mic_data_valid),
    .mic_data_retrieved (mic_data_retrieved),
    .mic_debug          (mic_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer reference for the mu-law byte.
  function automatic logic [7:0] ulaw_ref(input logic [15:0] d);
    int s, x, m, b, e, mant;
    logic sg;
    logic [2:0] ee;
    logic [3:0] mm;
    s  = int'($signed(d)) >>> 3;
    x  = s * 2;
    sg = (x < 0);
    m  = sg ? -x : x;
    if (m > 8158) m = 8158;
    b  = m + 33;
    e  = 0;
    for (int i = 5; i <= 12; i++) if (((b >> i) & 1) != 0) e = i - 5;
    mant = (b >> (e + 1)) & 15;
    ee = 3'(e);
    mm = 4'(mant);
    return ~{sg, ee, mm};
  endfunction

  function automatic logic [31:0] pop_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() > 0) w = {w[23:0], exp_q.pop_front()};
      else w = {w[23:0], 8'hxx};
    end
    return w;
  endfunction

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sample(input logic [15:0] d, input bit expect_packed);
    if (expect_packed) exp_q.push_back(ulaw_ref(d));
    sample_data  = d;
    sample_avail = 1'b1;
    cycle(3);
    sample_avail = 1'b0;
    cycle(3);
  endtask

  task automatic retrieve();
    mic_data_retrieved = 1'b1;
    cycle(1);
    mic_data_retrieved = 1'b0;
  endtask

  task automatic collect_word(output logic [31:0] w, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mic_data_valid === 1'b1) break;
      cycle(1);
    end
    ok = (mic_data_valid === 1'b1);
    w  = mic_data;
  endtask

  task automatic enter_active(input bit delay_sample);
    record_start = 1'b1;
    cycle(1);
    record_start = 1'b0;
    if (delay_sample) begin
      send_sample(16'h7FFF, 1'b0);
      cycle(START_DELAY - 6);
    end else begin
      cycle(START_DELAY);
    end
    tests_run++;
    if (mic_debug[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL delay_boundary: active=%b expected 0", mic_debug[0]);
    end
    cycle(1);
    tests_run++;
    if (mic_debug[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL active_entry: active=%b expected 1", mic_debug[0]);
    end
`ifdef MIC_SILENCE_PRELOAD_EN
    tests_run++;
    if (mic_data_valid !== 1'b1 || mic_data !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL silence_word: valid=%b data=%h expected 1 ffffffff", mic_data_valid, mic_data);
    end
    retrieve();
    tests_run++;
    if (mic_data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL silence_retrieve: valid=%b expected 0", mic_data_valid);
    end
`else
    tests_run++;
    if (mic_data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_preload: valid=%b expected 0", mic_data_valid);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(3);
    rst_n = 1'b1;
    cycle(2);
    tests_run++;
    if (mic_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h expected 00000000", mic_data);
    end
    tests_run++;
    if (mic_data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b expected 0", mic_data_valid);
    end
    tests_run++;
    if (mic_debug !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_debug: got %b expected 00", mic_debug);
    end
  endtask

  task automatic test_encoder();
    logic [31:0] w, e;
    bit ok;
    send_sample(16'h0001, 1'b1);
    send_sample(16'hFFFF, 1'b1);
    send_sample(16'h5A5A, 1'b1);
    send_sample(16'h0001, 1'b1);
    collect_word(w, ok);
    e = pop_word();
    tests_run++;
    if (!ok || w !== e) begin
      tests_failed++;
      $display("FAIL encoder_word: valid=%b got %h expected %h", ok, w, e);
    end
    tests_run++;
    if (w !== 32'hFF7E_89FF) begin
      tests_failed++;
      $display("FAIL encoder_const: got %h expected ff7e89ff", w);
    end
    tests_run++;
    if (mic_debug !== 2'b11) begin
      tests_failed++;
      $display("FAIL encoder_debug: got %b expected 11", mic_debug);
    end
    retrieve();
    tests_run++;
    if (mic_data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL retrieve_valid: got %b expected 0", mic_data_valid);
    end
  endtask

  task automatic test_extremes();
    logic [31:0] w, e;
    bit ok;
    send_sample(16'h7FFF, 1'b1);
    send_sample(16'h8000, 1'b1);
    send_sample(16'h0001, 1'b1);
    send_sample(16'hFFFF, 1'b1);
    collect_word(w, ok);
    e = pop_word();
    tests_run++;
    if (!ok || w !== e) begin
      tests_failed++;
      $display("FAIL extremes_word: valid=%b got %h expected %h", ok, w, e);
    end
    tests_run++;
    if (w !== 32'h8000_FF7E) begin
      tests_failed++;
      $display("FAIL extremes_const: got %h expected 8000ff7e", w);
    end
    retrieve();
  endtask

  task automatic test_latency();
    logic [31:0] w, e;
    bit ok;
    exp_q.push_back(ulaw_ref(16'h5A5A));
    sample_data  = 16'h5A5A;
    sample_avail = 1'b1;
    cycle(3);
    tests_run++;
    if (mic_data[31:24] !== 8'h80) begin
      tests_failed++;
      $display("FAIL latency_early: got %h expected 80", mic_data[31:24]);
    end
    cycle(1);
    tests_run++;
    if (mic_data[31:24] !== 8'h89) begin
      tests_failed++;
      $display("FAIL latency_edge4: got %h expected 89", mic_data[31:24]);
    end
    sample_avail = 1'b0;
    cycle(3);
    send_sample(16'h1234, 1'b1);
    send_sample(16'hC000, 1'b1);
    send_sample(16'h0100, 1'b1);
    collect_word(w, ok);
    e = pop_word();
    tests_run++;
    if (!ok || w !== e) begin
      tests_failed++;
      $display("FAIL latency_word: valid=%b got %h expected %h", ok, w, e);
    end
    retrieve();
  endtask

  task automatic test_overflow();
    logic [31:0] w, held, e;
    bit ok;
    send_sample(16'h0400, 1'b1);
    send_sample(16'hF000, 1'b1);
    send_sample(16'h0040, 1'b1);
    send_sample(16'hFF80, 1'b1);
    collect_word(held, ok);
    e = pop_word();
    tests_run++;
    if (!ok || held !== e) begin
      tests_failed++;
      $display("FAIL full_word: valid=%b got %h expected %h", ok, held, e);
    end
    send_sample(16'h0001, 1'b0);
    send_sample(16'h7FFF, 1'b1);
    tests_run++;
    if (mic_data_valid !== 1'b1 || mic_data !== held) begin
      tests_failed++;
      $display("FAIL full_hold: valid=%b got %h expected 1 %h", mic_data_valid, mic_data, held);
    end
    retrieve();
    send_sample(16'h2000, 1'b1);
    send_sample(16'hE000, 1'b1);
    send_sample(16'h0010, 1'b1);
    collect_word(w, ok);
    e = pop_word();
    tests_run++;
    if (!ok || w !== e) begin
      tests_failed++;
      $display("FAIL overflow_word: valid=%b got %h expected %h", ok, w, e);
    end
    tests_run++;
    if (w[31:24] !== 8'h80) begin
      tests_failed++;
      $display("FAIL overflow_slot0: got %h expected 80", w[31:24]);
    end
    retrieve();
  endtask

  task automatic test_start_stop();
    logic [31:0] w, e;
    bit ok;
    send_sample(16'h0001, 1'b1);
    send_sample(16'h0002, 1'b1);
    send_sample(16'h0800, 1'b1);
    send_sample(16'hA5A5, 1'b1);
    collect_word(w, ok);
    e = pop_word();
    tests_run++;
    if (!ok || w !== e) begin
      tests_failed++;
      $display("FAIL stop_word: valid=%b got %h expected %h", ok, w, e);
    end
    record_start = 1'b1;
    record_stop  = 1'b1;
    cycle(1);
    record_start = 1'b0;
    record_stop  = 1'b0;
    tests_run++;
    if (mic_debug !== 2'b00 || mic_data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_priority: debug=%b valid=%b expected 00 0", mic_debug, mic_data_valid);
    end
    cycle(START_DELAY + 3);
    tests_run++;
    if (mic_debug[0] !== 1'b0 || mic_data !== w) begin
      tests_failed++;
      $display("FAIL idle_retain: active=%b data=%h expected 0 %h", mic_debug[0], mic_data, w);
    end
  endtask

  task automatic test_reset_midword();
    logic [31:0] w, e;
    bit ok;
    enter_active(1'b0);
    send_sample(16'h4000, 1'b0);
    send_sample(16'hBEEF, 1'b0);
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (mic_data !== 32'h0 || mic_debug !== 2'b00) begin
      tests_failed++;
      $display("FAIL async_reset: data=%h debug=%b expected 00000000 00", mic_data, mic_debug);
    end
    cycle(2);
    rst_n = 1'b1;
    cycle(2);
    exp_q.delete();
    enter_active(1'b1);
    send_sample(16'hFFFF, 1'b1);
    send_sample(16'h0001, 1'b1);
    send_sample(16'h8000, 1'b1);
    send_sample(16'h5A5A, 1'b1);
    collect_word(w, ok);
    e = pop_word();
    tests_run++;
    if (!ok || w !== e) begin
      tests_failed++;
      $display("FAIL post_reset_word: valid=%b got %h expected %h", ok, w, e);
    end
    tests_run++;
    if (w !== 32'h7EFF_0089) begin
      tests_failed++;
      $display("FAIL post_reset_const: got %h expected 7eff0089", w);
    end
    retrieve();
  endtask

  initial begin
    tests_run          = 0;
    tests_failed       = 0;
    rst_n              = 1'b0;
    record_start       = 1'b0;
    record_stop        = 1'b0;
    sample_avail       = 1'b0;
    sample_data        = '0;
    mic_data_retrieved = 1'b0;

    test_reset();
    enter_active(1'b0);
    test_encoder();
    test_extremes();
    test_latency();
    test_overflow();
    test_start_stop();
    test_reset_midword();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
